// File: rtl/ram_fifo_pkg.sv
// Shared defaults and FSM state type for the RAM-backed FIFO controller.
package ram_fifo_pkg;

    localparam int unsigned DATA_W_DEF = 10;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DEPTH      = 256;

    typedef enum logic {
        IDLE = 1'b0,
        CLR  = 1'b1
    } state_e;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// Circular FIFO controller driving an external single-port synchronous RAM.
// Optional power-up clear sweep of the RAM is enabled with RAM_FIFO_CLEAR_EN.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PUSH_REQ,
    input  logic [DATA_W-1:0] PUSH_DATA,
    output logic              PUSH_RDY,
    input  logic              POP_REQ,
    output logic              POP_RDY,
    output logic [DATA_W-1:0] POP_DATA,
    output logic              POP_VALID,
    output logic [ADDR_W:0]   COUNT,
    output logic              FULL,
    output logic              EMPTY,
    output logic              BUSY,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_DIN,
    input  logic [DATA_W-1:0] RAM_DOUT
);

    localparam int unsigned DEPTH_L = 2 ** ADDR_W;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              pop_valid_q;
    logic              full, empty, busy;
    logic              push_acc, pop_acc;

`ifdef RAM_FIFO_CLEAR_EN
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    assign busy = (state_q == CLR);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (busy) begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == '1) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= CLR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        full     = (count_q == (ADDR_W + 1)'(DEPTH_L));
        empty    = (count_q == '0);
        POP_RDY  = !empty && !busy;
        // Pop has priority: a push stalls whenever a pop can be taken.
        PUSH_RDY = !full && !busy && !(POP_REQ && !empty);
        pop_acc  = POP_REQ && POP_RDY && !RST;
        push_acc = PUSH_REQ && PUSH_RDY && !RST;

        RAM_EN   = 1'b0;
        RAM_WE   = 1'b0;
        RAM_ADDR = '0;
        RAM_DIN  = '0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (RST) begin
            RAM_EN = 1'b0;
`ifdef RAM_FIFO_CLEAR_EN
        end else if (busy) begin
            RAM_EN   = 1'b1;
            RAM_WE   = 1'b1;
            RAM_ADDR = clr_addr_q;
`endif
        end else if (pop_acc) begin
            RAM_EN   = 1'b1;
            RAM_ADDR = rd_ptr_q;
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            count_d  = count_q - (ADDR_W + 1)'(1);
        end else if (push_acc) begin
            RAM_EN   = 1'b1;
            RAM_WE   = 1'b1;
            RAM_ADDR = wr_ptr_q;
            RAM_DIN  = PUSH_DATA;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            count_d  = count_q + (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_valid_q <= pop_acc;
        end
    end

    // RAM read data is only meaningful in the cycle after a read edge.
    assign POP_DATA  = pop_valid_q ? RAM_DOUT : '0;
    assign POP_VALID = pop_valid_q;
    assign COUNT     = count_q;
    assign FULL      = full;
    assign EMPTY     = empty;
    assign BUSY      = busy;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: behavioural RAM plus a queue-based
// reference model; honours RAM_FIFO_CLEAR_EN when defined.
module tb_ram_fifo_ctrl;

    localparam int unsigned DW = 10;
    localparam int unsigned AW = 8;
    localparam int unsigned DEPTH = 256;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          PUSH_REQ = 1'b0;
    logic [DW-1:0] PUSH_DATA = '0;
    logic          PUSH_RDY;
    logic          POP_REQ = 1'b0;
    logic          POP_RDY;
    logic [DW-1:0] POP_DATA;
    logic          POP_VALID;
    logic [AW:0]   COUNT;
    logic          FULL, EMPTY, BUSY;
    logic          RAM_EN, RAM_WE;
    logic [AW-1:0] RAM_ADDR;
    logic [DW-1:0] RAM_DIN;
    logic [DW-1:0] RAM_DOUT;

    logic [DW-1:0] mem [DEPTH];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model state
    int          q[$];
    int unsigned wptr = 0, rptr = 0;
    bit          m_busy = 1'b0;
    int unsigned clr_idx = 0;
    bit          exp_pv = 1'b0;
    int unsigned exp_pd = 0;

    always #5 CLK = ~CLK;

    ram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST(RST),
        .PUSH_REQ(PUSH_REQ), .PUSH_DATA(PUSH_DATA), .PUSH_RDY(PUSH_RDY),
        .POP_REQ(POP_REQ), .POP_RDY(POP_RDY), .POP_DATA(POP_DATA), .POP_VALID(POP_VALID),
        .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY), .BUSY(BUSY),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN),
        .RAM_DOUT(RAM_DOUT)
    );

    always @(posedge CLK) begin
        if (RAM_EN) begin
            if (RAM_WE) mem[RAM_ADDR] <= RAM_DIN;
            else        RAM_DOUT <= mem[RAM_ADDR];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    task automatic cycle(input bit push, input int unsigned data, input bit pop, input bit rst);
        int unsigned sz;
        bit          pop_acc;
        bit          push_acc;
        bit          push_ok;
        PUSH_REQ  = push;
        PUSH_DATA = DW'(data);
        POP_REQ   = pop;
        RST       = rst;
        #1;
        sz       = q.size();
        pop_acc  = 1'b0;
        push_acc = 1'b0;
        if (rst) begin
            check_eq("ram_en_rst", 32'(RAM_EN), 32'(0));
            check_eq("ram_we_rst", 32'(RAM_WE), 32'(0));
        end else if (m_busy) begin
            check_eq("push_rdy_busy", 32'(PUSH_RDY), 32'(0));
            check_eq("pop_rdy_busy", 32'(POP_RDY), 32'(0));
            check_eq("clr_en", 32'(RAM_EN), 32'(1));
            check_eq("clr_we", 32'(RAM_WE), 32'(1));
            check_eq("clr_addr", 32'(RAM_ADDR), clr_idx);
            check_eq("clr_din", 32'(RAM_DIN), 32'(0));
        end else begin
            push_ok  = (sz < DEPTH) && !(pop && sz > 0);
            pop_acc  = pop && (sz > 0);
            push_acc = push && push_ok;
            check_eq("pop_rdy", 32'(POP_RDY), 32'(sz > 0));
            check_eq("push_rdy", 32'(PUSH_RDY), 32'(push_ok));
            check_eq("ram_en", 32'(RAM_EN), 32'(pop_acc || push_acc));
            check_eq("ram_we", 32'(RAM_WE), 32'(push_acc));
            if (pop_acc)  check_eq("rd_addr", 32'(RAM_ADDR), rptr);
            if (push_acc) begin
                check_eq("wr_addr", 32'(RAM_ADDR), wptr);
                check_eq("wr_din", 32'(RAM_DIN), data % 1024);
            end
        end
        @(posedge CLK);
        #1;
        exp_pv = 1'b0;
        if (rst) begin
            q.delete();
            wptr = 0;
            rptr = 0;
            clr_idx = 0;
`ifdef RAM_FIFO_CLEAR_EN
            m_busy = 1'b1;
`else
            m_busy = 1'b0;
`endif
        end else if (m_busy) begin
            clr_idx++;
            if (clr_idx == DEPTH) m_busy = 1'b0;
        end else if (pop_acc) begin
            exp_pv = 1'b1;
            exp_pd = q.pop_front();
            rptr = (rptr + 1) % DEPTH;
        end else if (push_acc) begin
            q.push_back(data % 1024);
            wptr = (wptr + 1) % DEPTH;
        end
        check_eq("pop_valid", 32'(POP_VALID), 32'(exp_pv));
        if (exp_pv) check_eq("pop_data", 32'(POP_DATA), exp_pd);
        if (rst)    check_eq("pop_data_rst", 32'(POP_DATA), 32'(0));
        check_eq("count", 32'(COUNT), q.size());
        check_eq("full", 32'(FULL), 32'(q.size() == DEPTH));
        check_eq("empty", 32'(EMPTY), 32'(q.size() == 0));
        check_eq("busy", 32'(BUSY), 32'(m_busy));
    endtask

    task automatic drain_busy();
        for (int i = 0; i < 300 && m_busy; i++) cycle(1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        int unsigned p_push [6] = '{90, 10, 60, 97, 3, 50};
        int unsigned p_pop  [6] = '{30, 85, 60, 20, 97, 50};

        cycle(1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b0, 1'b1);
        drain_busy();

        // Basic push/pop of two words
        cycle(1'b1, 29, 1'b0, 1'b0);
        cycle(1'b1, 45, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);

        // Pop on empty is ignored
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);

        // Fill, overfill, drain, then wrap the pointers
        for (int i = 0; i < 256; i++) cycle(1'b1, i, 1'b0, 1'b0);
        cycle(1'b1, 999, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b1, 321, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);

        // Simultaneous push/pop: pop wins, push retries
        cycle(1'b1, 3, 1'b0, 1'b0);
        cycle(1'b1, 7, 1'b1, 1'b0);
        cycle(1'b1, 7, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);

        // Reset right after a pop accept discards the read
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b1, 1'b0);
        drain_busy();
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b1, 55, 1'b0, 1'b0);

        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 500; i++) begin
                cycle($urandom_range(99) < p_push[ph],
                      $urandom_range(1023),
                      $urandom_range(99) < p_pop[ph],
                      $urandom_range(399) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter DATA_W, 10, word width; matches RAM Din/Dout.
REQ-002 Parameter ADDR_W, 8, RAM address width; depth = 2**ADDR_W = 256.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 PUSH_REQ  input  1  push request; word on PUSH_DATA.
REQ-006 PUSH_DATA  input  DATA_W  word to enqueue.
REQ-007 PUSH_RDY  output  1  push accepted this cycle when PUSH_REQ && PUSH_RDY.
REQ-008 POP_REQ  input  1  pop request.
REQ-009 POP_RDY  output  1  pop accepted this cycle when POP_REQ && POP_RDY.
REQ-010 POP_DATA  output  DATA_W  dequeued word; valid only while POP_VALID.
REQ-011 POP_VALID  output  1  one-cycle strobe marking POP_DATA valid.
REQ-012 COUNT  output  ADDR_W+1  occupancy, 0..256.
REQ-013 FULL / EMPTY / BUSY  output  1 each  COUNT==256 / COUNT==0 / clear sweep running.
REQ-014 RAM_EN, RAM_WE  output  1 each  RAM enable / write enable.
REQ-015 RAM_ADDR  output  ADDR_W  RAM address.
REQ-016 RAM_DIN  output  DATA_W  RAM write data.
REQ-017 RAM_DOUT  input  DATA_W  RAM read data, valid one cycle after a read (EN=1, WE=0) edge.

Function
REQ-018 Block SHALL drive a single-port synchronous 256x10 RAM as a circular FIFO; at most one RAM access per cycle.
REQ-019 RAM_EN/RAM_WE/RAM_ADDR/RAM_DIN SHALL be combinational from state and accepted handshakes: push -> EN=1, WE=1, ADDR=wr_ptr, DIN=PUSH_DATA; pop -> EN=1, WE=0, ADDR=rd_ptr; otherwise EN=0, WE=0.
REQ-020 PUSH_RDY SHALL equal !FULL && !BUSY && !(POP_REQ && !EMPTY); POP_RDY SHALL equal !EMPTY && !BUSY.
REQ-021 Simultaneous push and pop: pop wins whenever EMPTY=0; push stalls (PUSH_RDY=0) and may retry next cycle; when EMPTY=1, push is accepted.
REQ-022 Pop latency SHALL be exactly 1: accept at edge k -> POP_VALID=1 and POP_DATA=RAM_DOUT during cycle k+1 only; back-to-back pops SHALL yield consecutive POP_VALID cycles.
REQ-023 wr_ptr/rd_ptr SHALL be ADDR_W bits, increment on accepted push/pop, wrap 255->0 without extra logic.
REQ-024 COUNT SHALL increment on push, decrement on pop; never both in one cycle; never exceeds 256 or drops below 0.
REQ-025 Push when FULL or pop when EMPTY SHALL be ignored: no RAM access, no pointer/COUNT change.
REQ-026 FSM states: IDLE (normal operation), CLR (clear sweep); CLR->IDLE after address 255 written.

Reset
REQ-027 RST=1 at an edge SHALL set wr_ptr=0, rd_ptr=0, COUNT=0, POP_VALID=0, POP_DATA=0, EMPTY=1, FULL=0; RAM contents are not cleared by RST itself.
REQ-028 RST mid-operation SHALL discard an in-flight read (no POP_VALID in the following cycle) and override any push/pop in the same cycle.
REQ-029 RAM_EN=0 and RAM_WE=0 while RST=1.

Configuration
REQ-030 Macro RAM_FIFO_CLEAR_EN defined: after RST deasserts, FSM enters CLR; for 256 cycles writes 0 to addresses 0..255 (EN=1, WE=1, DIN=0); BUSY=1, PUSH_RDY=POP_RDY=0 throughout; RST during CLR restarts the sweep.
REQ-031 Macro undefined: no CLR state; BUSY tied 0; FSM enters IDLE in the first cycle after reset.

Structure
REQ-032 Package ram_fifo_pkg SHALL hold DATA_W/ADDR_W defaults, DEPTH=256 and the FSM state typedef (IDLE, CLR).
REQ-033 No sub-module; the RAM is instantiated by the parent and connected through the RAM_* ports.

Verification
REQ-034 Reset, push 29 then 45, pop twice -> RAM writes addr 0=29, addr 1=45; POP_DATA 29 then 45, one-cycle POP_VALID each; COUNT 1,2,1,0; EMPTY=1 at end.
REQ-035 Push 256 words value=i -> FULL=1, PUSH_RDY=0; 257th push ignored (no RAM_WE); pop 256 -> values 0..255 in order; push/pop once more -> wr_ptr/rd_ptr wrap to 0 and 1.
REQ-036 COUNT=1 holding 3, PUSH_REQ=1 with data 7 and POP_REQ=1 same cycle -> pop accepted, POP_DATA=3 next cycle, PUSH_RDY=0; push of 7 accepted next cycle, COUNT ends 1.
REQ-037 POP_REQ on empty FIFO -> POP_RDY=0, RAM_EN=0, POP_VALID stays 0, COUNT stays 0.
REQ-038 RST asserted in cycle after pop accept -> POP_VALID=0, COUNT=0, EMPTY=1, wr_ptr=rd_ptr=0.
REQ-039 With RAM_FIFO_CLEAR_EN: after RST, BUSY=1 for exactly 256 cycles, RAM_WE=1 over addresses 0..255 with DIN=0; then pop on empty still yields no POP_VALID and push is accepted.
